ysyx_23060187_pc_unit: RTL and testbench

- Parametrised program-counter unit for the single-issue core.
- Presents the fetch address to the IFU over a valid/ready handshake.
- Accepts the control-flow result for that instruction from the EXU over a second handshake.
- Resolves all six RV32I/RV64I branch conditions internally and computes the next PC.
- Optionally raises an instruction-address-misaligned trap; sits between EXU and IFU.

---
 rtl/ysyx_23060187_pc_unit.sv | 146 ++++++++++++++
 tb/tb_ysyx_23060187_pc_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060187_pc_unit.sv
// ysyx_23060187_pc_unit: program-counter unit between EXU and IFU.
// Offers the fetch PC to the IFU, takes the control-flow result from the EXU,
// resolves branch conditions and loads the next PC.
// Optional feature macro: YSYX_23060187_PC_MISALIGN_TRAP_EN
//   defined   -> misaligned targets redirect to mtvec and pulse trap
//   undefined -> targets are forced word-aligned, trap/trap_tval tied to 0
module ysyx_23060187_pc_unit #(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] RST_VEC = XLEN'(32'h8000_0000)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            pc_valid,
   input  logic            pc_ready,
   output logic [XLEN-1:0] pc,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic            jal,
   input  logic            jalr,
   input  logic            br_en,
   input  logic [2:0]      br_funct3,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] mtvec,
   output logic            trap,
   output logic [XLEN-1:0] trap_tval
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] HALF_MASK = {{(XLEN-1){1'b1}}, 1'b0};

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            ex_ready_q, ex_ready_d;
   logic            trap_q, trap_d;
   logic [XLEN-1:0] tval_q, tval_d;

   logic            br_taken;
   logic            is_seq;
   logic [XLEN-1:0] target;
   logic            misaligned;
   logic [XLEN-1:0] pc_load;
   logic            trap_load;
   logic [XLEN-1:0] tval_load;

   // Branch condition resolution from funct3.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      br_taken = 1'b0;
      case (br_funct3)
         3'b000:  br_taken = (src1 == src2);
         3'b001:  br_taken = (src1 != src2);
         3'b100:  br_taken = ($signed(src1) <  $signed(src2));
         3'b101:  br_taken = ($signed(src1) >= $signed(src2));
         3'b110:  br_taken = (src1 <  src2);
         3'b111:  br_taken = (src1 >= src2);
         default: br_taken = 1'b0;
      endcase
   end

   // Target selection, priority jal > jalr > taken branch > sequential.
   always_comb begin
      is_seq = 1'b0;
      target = pc_q + XLEN'(4);
      if (jal) begin
         target = pc_q + imm;
      end else if (jalr) begin
         target = (src1 + imm) & HALF_MASK;
      end else if (br_en && br_taken) begin
         target = pc_q + imm;
      end else begin
         is_seq = 1'b1;
      end
   end

   // pc+4 from an aligned pc can never be misaligned, so only redirects are checked.
   assign misaligned = !is_seq && (target[1:0] != 2'b00);

`ifdef YSYX_23060187_PC_MISALIGN_TRAP_EN
   assign pc_load   = misaligned ? (mtvec & WORD_MASK) : target;
   assign trap_load = misaligned;
   assign tval_load = target;
`else
   logic unused_cfg;
   assign unused_cfg = ^{mtvec, misaligned};
   assign pc_load    = target & WORD_MASK;
   assign trap_load  = 1'b0;
   assign tval_load  = '0;
`endif

   // Next-state and next-output logic; outputs are registered from state_d.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      trap_d  = 1'b0;
      tval_d  = tval_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ:  if (pc_valid_q && pc_ready) state_d = WAIT;
         WAIT: begin
            if (ex_valid) begin
               state_d = REQ;
               pc_d    = pc_load;
               if (trap_load) begin
                  trap_d = 1'b1;
                  tval_d = tval_load;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      pc_valid_d = (state_d == REQ);
      ex_ready_d = (state_d == WAIT);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= RST_VEC;
         pc_valid_q <= 1'b0;
         ex_ready_q <= 1'b0;
         trap_q     <= 1'b0;
         tval_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         ex_ready_q <= ex_ready_d;
         trap_q     <= trap_d;
         tval_q     <= tval_d;
      end
   end

   assign pc        = pc_q;
   assign pc_valid  = pc_valid_q;
   assign ex_ready  = ex_ready_q;
   assign trap      = trap_q;
   assign trap_tval = tval_q;

endmodule

// File: tb/tb_ysyx_23060187_pc_unit.sv
// Testbench for ysyx_23060187_pc_unit: table-driven control-flow vectors
// (each from a fresh reset) plus sequences for sequential flow, stalls and
// reset in the middle of WAIT. Expected results go through a scoreboard queue.
module tb_ysyx_23060187_pc_unit;

   localparam int          XLEN    = 32;
   localparam logic [31:0] RST_VEC = 32'h8000_0000;
   localparam logic [31:0] MTVEC   = 32'h8000_0100;

   logic              clk;
   logic              rst_n;
   logic              pc_valid;
   logic              pc_ready;
   logic [XLEN-1:0]   pc;
   logic              ex_valid;
   logic              ex_ready;
   logic              jal;
   logic              jalr;
   logic              br_en;
   logic [2:0]        br_funct3;
   logic [XLEN-1:0]   src1;
   logic [XLEN-1:0]   src2;
   logic [XLEN-1:0]   imm;
   logic [XLEN-1:0]   mtvec;
   logic              trap;
   logic [XLEN-1:0]   trap_tval;

   ysyx_23060187_pc_unit #(.XLEN(XLEN), .RST_VEC(RST_VEC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pc_valid  (pc_valid),
      .pc_ready  (pc_ready),
      .pc        (pc),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .jal       (jal),
      .jalr      (jalr),
      .br_en     (br_en),
      .br_funct3 (br_funct3),
      .src1      (src1),
      .src2      (src2),
      .imm       (imm),
      .mtvec     (mtvec),
      .trap      (trap),
      .trap_tval (trap_tval)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        jal;
      logic        jalr;
      logic        br_en;
      logic [2:0]  f3;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] imm;
      logic [31:0] exp_pc;
      logic        exp_trap;
      logic [31:0] exp_tval;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        trap;
      logic [31:0] tval;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[13];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset(input bit check_bubble);
      rst_n     = 1'b0;
      pc_ready  = 1'b0;
      ex_valid  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      if (check_bubble) begin
         check("rst_pc", pc, RST_VEC);
         check("rst_pc_valid", pc_valid, 0);
         check("rst_ex_ready", ex_ready, 0);
         check("rst_trap", trap, 0);
         check("rst_tval", trap_tval, 0);
      end
      @(posedge clk);
      #1;
      if (check_bubble) check("rst_cycle1_pc_valid", pc_valid, 1);
   endtask

   task automatic fetch();
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (pc_valid === 1'b1) begin
            pc_ready = 1'b1;
            @(posedge clk);
            #1;
            pc_ready = 1'b0;
            check("fetch_ex_ready", ex_ready, 1);
            return;
         end
      end
      check("fetch_timeout", 0, 1);
   endtask

   task automatic exec(input vec_t v);
      exp_t e;
      logic [31:0] old_tval;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (ex_ready === 1'b1) begin
            jal       = v.jal;
            jalr      = v.jalr;
            br_en     = v.br_en;
            br_funct3 = v.f3;
            src1      = v.s1;
            src2      = v.s2;
            imm       = v.imm;
            ex_valid  = 1'b1;
            sb_q.push_back('{pc: v.exp_pc, trap: v.exp_trap, tval: v.exp_tval});
            @(posedge clk);
            #1;
            ex_valid = 1'b0;
            jal = 1'b0; jalr = 1'b0; br_en = 1'b0;
            e = sb_q.pop_front();
            check({v.name, "_pc"}, pc, e.pc);
            check({v.name, "_pc_valid"}, pc_valid, 1);
            check({v.name, "_trap"}, trap, e.trap);
            check({v.name, "_tval"}, trap_tval, e.tval);
            old_tval = trap_tval;
            @(posedge clk);
            #1;
            check({v.name, "_trap_pulse_end"}, trap, 0);
            check({v.name, "_tval_hold"}, trap_tval, old_tval);
            check({v.name, "_pc_hold"}, pc, e.pc);
            return;
         end
      end
      check({v.name, "_ex_timeout"}, 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        v;
      logic [31:0] pc_m;

      rst_n = 1'b0; pc_ready = 1'b0; ex_valid = 1'b0;
      jal = 1'b0; jalr = 1'b0; br_en = 1'b0; br_funct3 = 3'b000;
      src1 = '0; src2 = '0; imm = '0; mtvec = MTVEC;

      // All vectors start from pc = RST_VEC.
      vecs[0]  = '{"seq",       0, 0, 0, 3'b000, 32'h0,         32'h0, 32'h0,         32'h8000_0004, 0, 32'h0};
      vecs[1]  = '{"bne_eq",    0, 0, 1, 3'b001, 32'd5,         32'd5, 32'h10,        32'h8000_0004, 0, 32'h0};
      vecs[2]  = '{"beq_eq",    0, 0, 1, 3'b000, 32'd5,         32'd5, 32'h10,        32'h8000_0010, 0, 32'h0};
      vecs[3]  = '{"blt",       0, 0, 1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20,        32'h8000_0020, 0, 32'h0};
      vecs[4]  = '{"bltu",      0, 0, 1, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h20,        32'h8000_0004, 0, 32'h0};
      vecs[5]  = '{"f3_010",    0, 0, 1, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h20,        32'h8000_0004, 0, 32'h0};
      vecs[6]  = '{"bge",       0, 0, 1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h20,        32'h8000_0004, 0, 32'h0};
      vecs[7]  = '{"bgeu",      0, 0, 1, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h20,        32'h8000_0020, 0, 32'h0};
      vecs[8]  = '{"jal_jalr",  1, 1, 0, 3'b000, 32'h0000_1000, 32'd0, 32'h40,        32'h8000_0040, 0, 32'h0};
      vecs[9]  = '{"jal_neg",   1, 0, 0, 3'b000, 32'h0,         32'd0, 32'hFFFF_FFF8, 32'h7FFF_FFF8, 0, 32'h0};
      vecs[10] = '{"jalr_wrap", 0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'd0, 32'h20,        32'h0000_0010, 0, 32'h0};
`ifdef YSYX_23060187_PC_MISALIGN_TRAP_EN
      vecs[11] = '{"jalr_mis",  0, 1, 0, 3'b000, 32'h8000_1003, 32'd0, 32'h0,         32'h8000_0100, 1, 32'h8000_1002};
      vecs[12] = '{"jal_mis",   1, 0, 1, 3'b011, 32'h0,         32'd0, 32'h6,         32'h8000_0100, 1, 32'h8000_0006};
`else
      vecs[11] = '{"jalr_mis",  0, 1, 0, 3'b000, 32'h8000_1003, 32'd0, 32'h0,         32'h8000_1000, 0, 32'h0};
      vecs[12] = '{"jal_mis",   1, 0, 1, 3'b011, 32'h0,         32'd0, 32'h6,         32'h8000_0004, 0, 32'h0};
`endif

      // Table-driven control-flow vectors.
      for (int i = 0; i < 13; i++) begin
         do_reset(i == 0);
         fetch();
         exec(vecs[i]);
      end

      // Three sequential instructions, tracked by a simple +4 model.
      do_reset(1'b0);
      pc_m = RST_VEC;
      for (int i = 0; i < 3; i++) begin
         pc_m = pc_m + 32'd4;
         v = '{$sformatf("seq%0d", i), 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, pc_m, 0, 32'h0};
         fetch();
         exec(v);
      end
      check("seq_final_pc", pc, 32'h8000_000C);

      // IFU stall: pc and pc_valid hold with pc_ready low.
      do_reset(1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("stall_pc", pc, RST_VEC);
         check("stall_pc_valid", pc_valid, 1);
      end
      fetch();
      v = '{"jmp", 1, 0, 0, 3'b000, 32'h0, 32'h0, 32'h100, 32'h8000_0100, 0, 32'h0};
      exec(v);

      // EXU stall: ex_ready holds with ex_valid low.
      fetch();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("exstall_ex_ready", ex_ready, 1);
         check("exstall_pc", pc, 32'h8000_0100);
      end

      // Asynchronous reset in the middle of WAIT.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_pc", pc, RST_VEC);
      check("midrst_ex_ready", ex_ready, 0);
      check("midrst_pc_valid", pc_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_bubble", pc_valid, 0);
      @(posedge clk);
      #1;
      check("midrst_req", pc_valid, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
